// File: rtl/seq_ripple_subtractor_pkg.sv
// -----------------------------------------------------------------------------
// seq_ripple_subtractor_pkg
//   Shared definitions for the multi-cycle ripple subtractor:
//   - state_e     : FSM encoding (IDLE=0, RUN=1, DONE=2)
//   - cnt_width() : digit-counter width for N digits per operation,
//                   $clog2(N) with a floor of 1 so N=1 still gets a real counter
// -----------------------------------------------------------------------------
package seq_ripple_subtractor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_ripple_subtractor_fs.sv
// -----------------------------------------------------------------------------
// full_subtractor
//   One-bit full subtractor: diff = a - b - bin.
//   Ports:
//     a    in  1  minuend bit
//     b    in  1  subtrahend bit
//     bin  in  1  borrow in
//     diff out 1  difference bit
//     bout out 1  borrow out
// -----------------------------------------------------------------------------
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b ^ bin;
  // Borrow when b exceeds a outright, or when a==b and a borrow is pending.
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/seq_ripple_subtractor.sv
// -----------------------------------------------------------------------------
// seq_ripple_subtractor
//   Multi-cycle ripple subtractor: diff = a - b - bin, DIGIT bits per cycle,
//   WIDTH/DIGIT cycles per operation, one operation in flight.
//   Ports:
//     clk        in   1      rising-edge clock
//     reset      in   1      asynchronous active-high reset
//     in_valid   in   1      operands presented
//     in_ready   out  1      idle, will accept operands
//     a          in   WIDTH  minuend
//     b          in   WIDTH  subtrahend
//     bin        in   1      borrow in
//     out_valid  out  1      result and flags valid
//     out_ready  in   1      consumer accepts result
//     diff       out  WIDTH  a - b - bin mod 2^WIDTH
//     bout       out  1      unsigned borrow out
//     zero       out  1      diff == 0
//     ovf        out  1      signed overflow
// -----------------------------------------------------------------------------
module seq_ripple_subtractor
  import seq_ripple_subtractor_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic             brw_q, brw_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [DIGIT:0]       chain;
  logic [DIGIT-1:0]     dig;
  logic [WIDTH+DIGIT-1:0] res_cat;
  logic [WIDTH-1:0]     res_shift;

  // Digit datapath: DIGIT full subtractors rippling the borrow from the flop.
  assign chain[0] = brw_q;
  for (genvar i = 0; i < DIGIT; i++) begin : g_fs
    full_subtractor u_fs (
      .a    (a_sh_q[i]),
      .b    (b_sh_q[i]),
      .bin  (chain[i]),
      .diff (dig[i]),
      .bout (chain[i+1])
    );
  end

  // New digit enters at the MSB end; after N shifts digit 0 sits at the LSB.
  assign res_cat   = {dig, res_q};
  assign res_shift = res_cat[WIDTH+DIGIT-1:DIGIT];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    brw_d       = brw_q;
    res_d       = res_q;
    a_msb_d     = a_msb_q;
    b_msb_d     = b_msb_q;
    diff_d      = diff_q;
    bout_d      = bout_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_sh_d     = a;
          b_sh_d     = b;
          brw_d      = bin;
          cnt_d      = '0;
          // Shift registers are consumed, so the sign bits are kept for ovf.
          a_msb_d    = a[WIDTH-1];
          b_msb_d    = b[WIDTH-1];
          in_ready_d = 1'b0;
          state_d    = ST_RUN;
        end
      end
      ST_RUN: begin
        a_sh_d = a_sh_q >> DIGIT;
        b_sh_d = b_sh_q >> DIGIT;
        brw_d  = chain[DIGIT];
        res_d  = res_shift;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          cnt_d       = '0;
          diff_d      = res_shift;
          bout_d      = chain[DIGIT];
          zero_d      = (res_shift == '0);
          ovf_d       = (a_msb_q != b_msb_q) && (res_shift[WIDTH-1] != a_msb_q);
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      brw_q       <= 1'b0;
      res_q       <= '0;
      a_msb_q     <= 1'b0;
      b_msb_q     <= 1'b0;
      diff_q      <= '0;
      bout_q      <= 1'b0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      brw_q       <= brw_d;
      res_q       <= res_d;
      a_msb_q     <= a_msb_d;
      b_msb_q     <= b_msb_d;
      diff_q      <= diff_d;
      bout_q      <= bout_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_seq_ripple_subtractor.sv
// -----------------------------------------------------------------------------
// tb_seq_ripple_subtractor
//   Directed bench: a DIGIT=1 instance driven from a vector table plus
//   hand-written sequences (DONE hold, reset mid-RUN), and a DIGIT=2 instance
//   for the latency-4 case.
// -----------------------------------------------------------------------------
module tb_seq_ripple_subtractor;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid, out_ready, bin;
  logic [7:0] a, b;
  logic       in_ready, out_valid, bout, zero, ovf;
  logic [7:0] diff;

  logic       in_valid2, out_ready2, bin2;
  logic [7:0] a2, b2;
  logic       in_ready2, out_valid2, bout2, zero2, ovf2;
  logic [7:0] diff2;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  seq_ripple_subtractor #(.WIDTH(8), .DIGIT(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout), .zero(zero), .ovf(ovf)
  );

  seq_ripple_subtractor #(.WIDTH(8), .DIGIT(2)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2), .bin(bin2), .out_valid(out_valid2), .out_ready(out_ready2),
    .diff(diff2), .bout(bout2), .zero(zero2), .ovf(ovf2)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] diff;
    logic       bout;
    logic       zero;
    logic       ovf;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present one operation to the DIGIT=1 instance and wait for out_valid.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic tbin,
                        output int lat);
    @(negedge clk);
    a = ta; b = tb; bin = tbin; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  vec_t vecs[9];
  int   lat;
  logic [7:0] held;

  initial begin
    vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{8'h2A, 8'h2A, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{8'h2A, 8'h2A, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b0};

    reset = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; bin = 1'b0;
    in_valid2 = 1'b0; out_ready2 = 1'b0; a2 = '0; b2 = '0; bin2 = 1'b0;
    #3;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_diff", diff, 0);
    chk("rst_flags", {bout, zero, ovf}, 0);
    chk("rst_in_ready2", in_ready2, 1);
    chk("rst_out_valid2", out_valid2, 0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    // Table-driven vectors
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("v%0d_in_ready", i), in_ready, 1);
      run_op(vecs[i].a, vecs[i].b, vecs[i].bin, lat);
      chk($sformatf("v%0d_latency", i), lat, 8);
      chk($sformatf("v%0d_diff", i), diff, vecs[i].diff);
      chk($sformatf("v%0d_bout", i), bout, vecs[i].bout);
      chk($sformatf("v%0d_zero", i), zero, vecs[i].zero);
      chk($sformatf("v%0d_ovf", i), ovf, vecs[i].ovf);
      release_out();
      chk($sformatf("v%0d_idle_in_ready", i), in_ready, 1);
      chk($sformatf("v%0d_idle_out_valid", i), out_valid, 0);
    end

    // Hold in DONE with out_ready low while new operands are pulsed
    run_op(8'h03, 8'h05, 1'b0, lat);
    chk("hold_latency", lat, 8);
    held = diff;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = 1'b1; a = 8'h40 + 8'(k); b = 8'h01; bin = 1'b0;
      @(posedge clk); #1;
      chk($sformatf("hold%0d_out_valid", k), out_valid, 1);
      chk($sformatf("hold%0d_diff", k), diff, 8'hFE);
      chk($sformatf("hold%0d_bout", k), bout, 1);
      chk($sformatf("hold%0d_in_ready", k), in_ready, 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("hold_diff_stable", diff, held);
    release_out();
    chk("hold_rel_in_ready", in_ready, 1);
    chk("hold_rel_out_valid", out_valid, 0);
    @(posedge clk); #1;
    chk("hold_stay_idle", in_ready, 1);

    // Reset during the 4th RUN cycle; previous diff/bout are nonzero
    @(negedge clk);
    a = 8'h55; b = 8'h22; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_diff", diff, 0);
    chk("arst_flags", {bout, zero, ovf}, 0);
    chk("arst_in_ready", in_ready, 1);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out_valid", out_valid, 0);
    run_op(8'h10, 8'h01, 1'b0, lat);
    chk("post_rst_latency", lat, 8);
    chk("post_rst_diff", diff, 8'h0F);
    chk("post_rst_bout", bout, 0);
    release_out();

    // DIGIT=2 instance: same as the first vector, latency 4
    chk("d2_in_ready", in_ready2, 1);
    @(negedge clk);
    a2 = 8'h05; b2 = 8'h03; bin2 = 1'b0; in_valid2 = 1'b1;
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    lat = 0;
    while (out_valid2 !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("d2_latency", lat, 4);
    chk("d2_diff", diff2, 8'h02);
    chk("d2_flags", {bout2, zero2, ovf2}, 0);
    @(negedge clk);
    out_ready2 = 1'b1;
    @(posedge clk); #1;
    out_ready2 = 1'b0;
    chk("d2_rel_in_ready", in_ready2, 1);
    chk("d2_rel_out_valid", out_valid2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
